if_fetch_queue: RTL
===================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end that supersedes the single PC register and single IF/ID register with a decoupled fetch queue.
- Owns the PC and drives the instruction-memory address.
- Buffers up to DEPTH fetched entries {inst, PC, PC+4}.
- Presents the oldest entry to ID over a valid/ready handshake.
- Flushes everything on a redirect (branch, jal/jalr, trap, mret) from later stages.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0001_0000, PC value after reset
NOP_INST, 32'h0000_0013, o_inst value when queue empty (addi x0,x0,0)

Ports:
clk  input  1  clock
reset_x  input  1  synchronous active-low reset
o_imemAddr  output  XLEN  current fetch PC to instruction memory
i_imemInst  input  32  instruction at o_imemAddr, same cycle (combinational imem)
i_redirect  input  1  flush queue and load new PC this cycle
i_redirectPC  input  XLEN  redirect target
o_valid  output  1  head entry valid for ID
i_ready  input  1  ID accepts head entry (ID not stalled)
o_inst  output  32  head instruction
o_PC  output  XLEN  head PC
o_PCPlus4  output  XLEN  head PC+4
o_count  output  $clog2(DEPTH+1)  current occupancy
o_full  output  1  count == DEPTH

Behaviour:
- One clock, clk. Reset is synchronous and active-low on reset_x; all state updates only on the rising edge.
- Reset (reset_x=0 at an edge) sets:
  - PC = RESET_PC.
  - read/write pointers = 0, count = 0.
  - o_valid = 0, o_full = 0, o_count = 0.
  - o_inst = NOP_INST, o_PC = 0, o_PCPlus4 = 0.
- Reset mid-operation discards all entries and any redirect presented in the same cycle.
- o_imemAddr = PC register at all times.
- Push rule: push = ~i_redirect & (count < DEPTH | pop). When push is set:
  - write entry {i_imemInst, PC, PC+XLEN'd4} at the write pointer;
  - PC <= PC + 4 (mod 2^XLEN).
- No push means PC holds.
- Pop rule: pop = o_valid & i_ready & ~i_redirect. When pop is set, the read pointer advances.
- o_valid = (count != 0) & ~i_redirect.
- Output mux: o_inst/o_PC/o_PCPlus4 show the entry at the read pointer when count != 0; otherwise NOP_INST/0/0.
- Latency: an instruction fetched at edge N is visible at the head after edge N. Empty-to-valid takes exactly 1 cycle; there is no bypass from i_imemInst to o_inst.
- Throughput: 1 entry/cycle sustained while i_ready=1.
- Count update: count <= count + push - pop.
  - Push and pop in the same cycle while full is legal; count stays DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Redirect has priority over push and pop:
  - count, read pointer and write pointer <= 0;
  - PC <= {i_redirectPC[XLEN-1:1], 1'b0} (bit 0 cleared, as for jalr);
  - no entry is written and none is consumed;
  - the first fetch from the new PC occurs in the next cycle.
- Redirect while empty or full behaves identically.
- Back-to-back redirects: the last one wins; each redirect cycle forces o_valid=0.
- Backpressure (i_ready=0): entries hold, and the head outputs are stable while o_valid=1.
  - Fetch continues until count == DEPTH, then PC freezes.
- Full: o_full=1 and o_imemAddr holds the next unfetched PC. Fetch resumes in the same cycle as the pop that frees a slot.
- Memory has no reset requirement; validity is governed only by count.

Test Plan:
1. Reset with DEPTH=4, then release, i_ready=1, imem returns inst=PC -> o_imemAddr sequence 0x10000, 0x10004, ...; o_valid rises one cycle after release; o_PC follows 0x10000, 0x10004, ... one per cycle; o_PCPlus4 = o_PC+4.
2. Hold i_ready=0 from reset -> after 4 cycles o_count=4 and o_full=1, o_imemAddr frozen at 0x10010, head stays 0x10000. Raise i_ready for one cycle -> head 0x10004, count stays 4, 0x10010 fetched that cycle.
3. Queue holds 3 entries; assert i_redirect with i_redirectPC=0x20001 plus i_ready=1 -> that cycle o_valid=0 and no pop. Next cycle count=0, o_imemAddr=0x20000. The cycle after: o_valid=1, o_PC=0x20000.
4. Redirect on two consecutive cycles (0x30000 then 0x40000) -> o_valid=0 in both; the first valid head has o_PC=0x40000; no 0x30000 entry is ever presented.
5. Pulse reset_x=0 for one cycle while count=2 and a redirect is asserted -> o_count=0, o_valid=0, o_inst=0x00000013; fetch restarts at 0x10000.
6. Random i_ready (50%) with periodic redirects over 10k cycles vs. a reference queue model -> no dropped, duplicated or reordered PCs between redirects; o_count never exceeds 4.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end. It owns the PC, drives imem, and buffers
// up to DEPTH {inst, PC, PC+4} entries for ID behind a valid/ready handshake.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0001_0000),
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset_x,
  output logic [XLEN-1:0]            o_imemAddr,
  input  logic [31:0]                i_imemInst,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirectPC,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_inst,
  output logic [XLEN-1:0]            o_PC,
  output logic [XLEN-1:0]            o_PCPlus4,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] pc4_mem  [DEPTH];

  logic non_empty;
  logic pop;
  logic push;

  // A redirect suppresses both sides; a pop frees a slot for a same-cycle push when full.
  assign non_empty = (count != '0);
  assign pop       = non_empty & i_ready & ~i_redirect;
  assign push      = ~i_redirect & ((count < CW'(DEPTH)) | pop);

  assign o_imemAddr = pc;
  assign o_valid    = non_empty & ~i_redirect;
  assign o_count    = count;
  assign o_full     = (count == CW'(DEPTH));

  always_comb begin
    o_inst    = NOP_INST;
    o_PC      = '0;
    o_PCPlus4 = '0;
    if (non_empty) begin
      o_inst    = inst_mem[rd_ptr];
      o_PC      = pc_mem[rd_ptr];
      o_PCPlus4 = pc4_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      pc     <= {i_redirectPC[XLEN-1:1], 1'b0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= i_imemInst;
      pc_mem[wr_ptr]   <= pc;
      pc4_mem[wr_ptr]  <= pc + XLEN'(4);
    end
  end

endmodule
